// File: rtl/mux_r_in.sv
// rtl/mux_r_in.sv - registered 8-bit source mux for the register-file write port
// Optional flag flops (CARRY, ZERO) exist only when MUXR_IN_FLAGS_EN is defined.
module mux_r_in (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] RY,
  input  logic [7:0] RY_DATO,
  input  logic [7:0] DATO_IN,
  input  logic [2:0] SELEC,
`ifdef MUXR_IN_FLAGS_EN
  output logic       CARRY,
  output logic       ZERO,
`endif
  output logic [7:0] DATO
);

`ifdef MUXR_IN_FLAGS_EN
  logic [8:0] sum;
  assign sum = {1'b0, RY_DATO} + {1'b0, DATO_IN};
`else
  logic [7:0] sum;
  assign sum = RY_DATO + DATO_IN;
`endif

  logic [7:0] next_dato;
  logic       hold;

  always_comb begin
    next_dato = 8'h00;
    hold      = 1'b0;
    case (SELEC)
      3'b000: next_dato = 8'h00;
      3'b001: next_dato = DATO_IN;
      3'b010: next_dato = RY_DATO;
      3'b011: next_dato = {5'b00000, RY};
      3'b100: next_dato = sum[7:0];
      3'b101: next_dato = RY_DATO & DATO_IN;
      3'b110: next_dato = RY_DATO | DATO_IN;
      3'b111: hold      = 1'b1;
      default: next_dato = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATO <= 8'h00;
    end else if (!hold) begin
      DATO <= next_dato;
    end
  end

`ifdef MUXR_IN_FLAGS_EN
  // Carry is only meaningful for the add; every other loading code clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CARRY <= 1'b0;
      ZERO  <= 1'b1;
    end else if (!hold) begin
      CARRY <= (SELEC == 3'b100) ? sum[8] : 1'b0;
      ZERO  <= (next_dato == 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_mux_r_in.sv
// tb/tb_mux_r_in.sv - randomized self-checking bench for mux_r_in against a behavioural model
module tb_mux_r_in;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] RY = '0;
  logic [7:0] RY_DATO = '0;
  logic [7:0] DATO_IN = '0;
  logic [2:0] SELEC = '0;
  logic [7:0] DATO;
`ifdef MUXR_IN_FLAGS_EN
  logic       CARRY;
  logic       ZERO;
`endif

  mux_r_in dut (
    .CLK(CLK),
    .RST(RST),
    .RY(RY),
    .RY_DATO(RY_DATO),
    .DATO_IN(DATO_IN),
    .SELEC(SELEC),
`ifdef MUXR_IN_FLAGS_EN
    .CARRY(CARRY),
    .ZERO(ZERO),
`endif
    .DATO(DATO)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_dato  = 8'h00;
  logic       m_carry = 1'b0;
  logic       m_zero  = 1'b1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dato"}, DATO, m_dato);
`ifdef MUXR_IN_FLAGS_EN
    check({tag, ".carry"}, {7'd0, CARRY}, {7'd0, m_carry});
    check({tag, ".zero"}, {7'd0, ZERO}, {7'd0, m_zero});
`endif
  endtask

  // Model: integer arithmetic straight from the select-code table.
  task automatic model_edge(input logic [2:0] sel, input logic [7:0] rd,
                            input logic [7:0] di, input logic [2:0] ry);
    int s;
    int nd;
    bit nc;
    s  = int'(rd) + int'(di);
    nc = 1'b0;
    nd = 0;
    if (sel == 3'd7) return;
    if (sel == 3'd1) nd = di;
    if (sel == 3'd2) nd = rd;
    if (sel == 3'd3) nd = ry;
    if (sel == 3'd4) begin nd = s % 256; nc = (s > 255); end
    if (sel == 3'd5) nd = rd & di;
    if (sel == 3'd6) nd = rd | di;
    m_dato  = nd[7:0];
    m_carry = nc;
    m_zero  = (nd == 0);
  endtask

  task automatic model_reset();
    m_dato  = 8'h00;
    m_carry = 1'b0;
    m_zero  = 1'b1;
  endtask

  // Inputs are applied 1 time unit after a rising edge, checked 1 unit after the next.
  task automatic step(input logic [2:0] sel, input logic [7:0] rd,
                      input logic [7:0] di, input logic [2:0] ry, input string tag);
    SELEC = sel; RY_DATO = rd; DATO_IN = di; RY = ry;
    @(posedge CLK);
    model_edge(sel, rd, di, ry);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic reset_pulse(input string tag);
    #3 RST = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    #2 RST = 1'b0;
  endtask

  initial begin
    #3;
    model_reset();
    check_outputs("por");
    #4 RST = 1'b0;
    @(posedge CLK); #1;

    step(3'b010, 8'h33, 8'h00, 3'd0, "pre_load");
    SELEC = 3'b001; DATO_IN = 8'h0F;
    reset_pulse("mid_reset");
    step(3'b001, 8'hAA, 8'h0F, 3'd5, "post_reset_sel001");

    step(3'b001, 8'hAA, 8'h0F, 3'd5, "sel001");
    step(3'b010, 8'hAA, 8'h0F, 3'd5, "sel010");
    step(3'b011, 8'hAA, 8'h0F, 3'd5, "sel011");
    check("sel011_const", DATO, 8'h05);
    step(3'b100, 8'hAA, 8'h0F, 3'd5, "sel100");
    check("sel100_const", DATO, 8'hB9);
    step(3'b101, 8'hAA, 8'h0F, 3'd5, "sel101");
    check("sel101_const", DATO, 8'h0A);
    step(3'b110, 8'hAA, 8'h0F, 3'd5, "sel110");
    check("sel110_const", DATO, 8'hAF);

    step(3'b100, 8'hFF, 8'h01, 3'd0, "wrap");
    check("wrap_const", DATO, 8'h00);
`ifdef MUXR_IN_FLAGS_EN
    check("wrap_carry_const", {7'd0, CARRY}, 8'h01);
`endif

    step(3'b010, 8'hAA, 8'h00, 3'd0, "hold_load");
    for (int i = 0; i < 3; i++)
      step(3'b111, 8'($urandom), 8'($urandom), 3'($urandom), "hold");
    check("hold_const", DATO, 8'hAA);
    step(3'b000, 8'h5A, 8'hA5, 3'd7, "clear");

    step(3'b100, 8'h80, 8'h80, 3'd0, "carry_load");
    step(3'b111, 8'h01, 8'h01, 3'd1, "carry_hold");

    SELEC = 3'b111;
    reset_pulse("reset_over_hold");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse("rand_reset");
      step(3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
